bram_arbiter: RTL and testbench

- Shares one 256x16 iCE40 block RAM (ice_bram, 1-cycle synchronous read) between NREQ requesters, for example CPU, video scan-out and DMA.
- Grants at most one access per clock using round-robin, with a valid/ready handshake per requester.
- Returns read data on a per-requester response strobe.
- Sits between the requesters and the ice_bram instance. Both BRAM clocks are tied to clk.

---
 rtl/bram_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/bram_arbiter.sv | 119 +++++++++++
 tb/tb_bram_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared constants and helpers for the block-RAM arbiter.
package bram_pkg;

  localparam int unsigned BRAM_AW = 8;
  localparam int unsigned BRAM_DW = 16;
  localparam int unsigned MAX_REQ = 4;
  localparam int unsigned IDX_W   = 2;

  // Binary index of the set bit of a one-hot (or zero) vector.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last
// granted requester and wraps around.
module rr_arbiter
  import bram_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_grant_i,
  output logic [NREQ-1:0]  grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             any_o
);

  logic [MAX_REQ-1:0] grant_wide;
  logic               found;

  // Pick the first pending requester in rotated priority order.
  always_comb begin
    grant_o    = '0;
    found      = 1'b0;
    grant_wide = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (!found && req_i[i] && (i == (32'(last_grant_i) + off) % NREQ)) begin
          grant_o[i] = 1'b1;
          found      = 1'b1;
        end
      end
    end
    grant_wide[NREQ-1:0] = grant_o;
    grant_idx_o          = onehot_to_idx(grant_wide);
    any_o                = found;
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one 256x16 synchronous-read block RAM between NREQ requesters,
// one access per clock, round-robin, with a 1-cycle read response strobe.
module bram_arbiter
  import bram_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned AW   = BRAM_AW,
  parameter int unsigned DW   = BRAM_DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic [AW-1:0]      bram_raddr,
  input  logic [DW-1:0]      bram_rdata,
  output logic               bram_we,
  output logic [AW-1:0]      bram_waddr,
  output logic [DW-1:0]      bram_wdata
);

  logic [NREQ-1:0]  grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_any;
  logic             xfer;

  logic [AW-1:0]    win_addr;
  logic [DW-1:0]    win_wdata;
  logic             win_we;

  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic             rsp_pend_q, rsp_pend_d;
  logic [IDX_W-1:0] rsp_owner_q, rsp_owner_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .grant_idx_o  (grant_idx),
    .any_o        (grant_any)
  );

  // Select the winner's address, data and direction.
  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_we    = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        win_addr  = req_addr[i*AW +: AW];
        win_wdata = req_wdata[i*DW +: DW];
        win_we    = req_we[i];
      end
    end
  end

  // Handshake and BRAM drive; reset gates ready and write enable so no
  // access can slip through while reset is asserted.
  always_comb begin
    xfer       = grant_any & ~rst;
    req_ready  = rst ? '0 : grant;
    bram_we    = xfer & win_we;
    bram_raddr = xfer ? win_addr  : addr_q;
    bram_waddr = xfer ? win_addr  : addr_q;
    bram_wdata = xfer ? win_wdata : wdata_q;
  end

  // Next-state: pointer advances and the read response is armed only on a transfer.
  always_comb begin
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rsp_pend_d   = 1'b0;
    rsp_owner_d  = rsp_owner_q;
    if (xfer) begin
      last_grant_d = grant_idx;
      addr_d       = win_addr;
      wdata_d      = win_wdata;
      rsp_pend_d   = ~win_we;
      if (!win_we) rsp_owner_d = grant_idx;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= IDX_W'(NREQ - 1);
      rsp_pend_q   <= 1'b0;
      rsp_owner_q  <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rsp_pend_q   <= rsp_pend_d;
      rsp_owner_q  <= rsp_owner_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Response strobe to the owner of the previous cycle's read; data passes straight through.
  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      rsp_valid[i] = rsp_pend_q && (rsp_owner_q == IDX_W'(i));
    end
    rsp_data = bram_rdata;
  end

  a_ready_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_rsp_onehot0   : assert property (@(posedge clk) disable iff (rst) $onehot0(rsp_valid));

endmodule

// File: tb/tb_bram_arbiter.sv
`timescale 1ns/1ps
module tb_bram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: two requesters with a behavioural BRAM.
  logic [1:0]  a_valid, a_ready, a_we, a_rsp_valid;
  logic [15:0] a_addr;
  logic [31:0] a_wdata;
  logic [15:0] a_rsp_data, a_rdata, a_bwdata;
  logic [7:0]  a_raddr, a_waddr;
  logic        a_bwe;

  // Instance B: four requesters, BRAM read data tied to a constant.
  logic [3:0]  b_valid, b_ready, b_we, b_rsp_valid;
  logic [31:0] b_addr;
  logic [63:0] b_wdata;
  logic [15:0] b_rsp_data, b_bwdata;
  logic [15:0] b_rdata = 16'hA5A5;
  logic [7:0]  b_raddr, b_waddr;
  logic        b_bwe;

  bram_arbiter #(.NREQ(2)) dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_addr(a_addr), .req_wdata(a_wdata),
    .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data),
    .bram_raddr(a_raddr), .bram_rdata(a_rdata), .bram_we(a_bwe),
    .bram_waddr(a_waddr), .bram_wdata(a_bwdata)
  );

  bram_arbiter #(.NREQ(4)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_addr(b_addr), .req_wdata(b_wdata),
    .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
    .bram_raddr(b_raddr), .bram_rdata(b_rdata), .bram_we(b_bwe),
    .bram_waddr(b_waddr), .bram_wdata(b_bwdata)
  );

  logic [15:0] mem_a [256];
  int wcnt_ff = 0;
  always @(posedge clk) begin
    if (a_bwe) mem_a[a_waddr] <= a_bwdata;
    a_rdata <= mem_a[a_raddr];
    if (a_bwe && a_waddr == 8'hFF) wcnt_ff <= wcnt_ff + 1;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_rdy, prev_rdy;
  logic [3:0] exp_b, prev_b;

  initial begin
    // Reset: requests present but everything gated.
    a_valid = 2'b11; a_we = 2'b11; a_addr = 16'h3412; a_wdata = 32'h1234_5678;
    b_valid = 4'b0000; b_we = 4'b0000; b_addr = '0; b_wdata = '0;
    #2;
    check("rst_ready", 32'(a_ready), 32'h0);
    check("rst_we", 32'(a_bwe), 32'h0);
    check("rst_rsp", 32'(a_rsp_valid), 32'h0);
    check("rst_b_rsp", 32'(b_rsp_valid), 32'h0);
    tick();
    rst = 1'b0;

    // Single write by requester 0: 0xBEEF -> 0x12.
    a_valid = 2'b01; a_we = 2'b01; a_addr = {8'h00, 8'h12}; a_wdata = {16'h0000, 16'hBEEF};
    #1;
    check("wr_ready", 32'(a_ready), 32'h1);
    check("wr_we", 32'(a_bwe), 32'h1);
    check("wr_waddr", 32'(a_waddr), 32'h12);
    check("wr_wdata", 32'(a_bwdata), 32'hBEEF);
    check("wr_rsp", 32'(a_rsp_valid), 32'h0);
    tick();

    // Read-back by requester 1.
    a_valid = 2'b10; a_we = 2'b00; a_addr = {8'h12, 8'h00};
    #1;
    check("rd_ready", 32'(a_ready), 32'h2);
    check("rd_we", 32'(a_bwe), 32'h0);
    check("rd_raddr", 32'(a_raddr), 32'h12);
    check("wr_norsp", 32'(a_rsp_valid), 32'h0);
    tick();
    a_valid = 2'b00;
    #1;
    check("rd_rsp", 32'(a_rsp_valid), 32'h2);
    check("rd_data", 32'(a_rsp_data), 32'hBEEF);
    check("idle_ready", 32'(a_ready), 32'h0);
    check("idle_we", 32'(a_bwe), 32'h0);
    tick();
    check("idle_rsp", 32'(a_rsp_valid), 32'h0);

    // Preload: req0 writes 0x01=0x1111, then req1 writes 0x02=0x2222 (last grant = 1).
    a_valid = 2'b01; a_we = 2'b01; a_addr = 16'h0001; a_wdata = 32'h0000_1111;
    tick();
    a_valid = 2'b10; a_we = 2'b10; a_addr = 16'h0200; a_wdata = 32'h2222_0000;
    #1;
    check("pre_ready", 32'(a_ready), 32'h2);
    tick();

    // Contention: both read for 6 cycles, grants alternate 0,1,0,1,0,1.
    a_valid = 2'b11; a_we = 2'b00; a_addr = {8'h02, 8'h01};
    prev_rdy = 2'b00;
    for (int k = 0; k < 6; k++) begin
      exp_rdy = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1;
      check("cont_ready", 32'(a_ready), 32'(exp_rdy));
      check("cont_rsp", 32'(a_rsp_valid), 32'(prev_rdy));
      if (prev_rdy != 2'b00)
        check("cont_data", 32'(a_rsp_data), (prev_rdy == 2'b01) ? 32'h1111 : 32'h2222);
      prev_rdy = exp_rdy;
      tick();
    end

    // Stall hold: req0 reads alone, then req1's write wins over req0.
    a_valid = 2'b01; a_addr = {8'hFF, 8'h01};
    #1;
    check("h0_ready", 32'(a_ready), 32'h1);
    check("h0_rsp", 32'(a_rsp_valid), 32'h2);
    check("h0_data", 32'(a_rsp_data), 32'h2222);
    tick();
    a_valid = 2'b11; a_we = 2'b10; a_addr = {8'hFF, 8'h02}; a_wdata = 32'h0055_0000;
    #1;
    check("h1_ready", 32'(a_ready), 32'h2);
    check("h1_we", 32'(a_bwe), 32'h1);
    check("h1_waddr", 32'(a_waddr), 32'hFF);
    check("h1_wdata", 32'(a_bwdata), 32'h0055);
    check("h1_data", 32'(a_rsp_data), 32'h1111);
    tick();
    a_valid = 2'b01;
    #1;
    check("h2_ready", 32'(a_ready), 32'h1);
    check("h2_we", 32'(a_bwe), 32'h0);
    check("h2_rsp", 32'(a_rsp_valid), 32'h0);
    tick();
    a_valid = 2'b10; a_we = 2'b00;
    #1;
    check("h3_ready", 32'(a_ready), 32'h2);
    check("h3_rsp", 32'(a_rsp_valid), 32'h1);
    check("h3_data", 32'(a_rsp_data), 32'h2222);
    tick();
    a_valid = 2'b00;
    #1;
    check("h4_rsp", 32'(a_rsp_valid), 32'h2);
    check("h4_data", 32'(a_rsp_data), 32'h0055);
    check("h4_wcount", 32'(wcnt_ff), 32'h1);
    tick();

    // Async reset: squash a response already strobing, and block a pending read.
    a_valid = 2'b01; a_addr = 16'h0001;
    #1;
    check("ar_ready", 32'(a_ready), 32'h1);
    tick();
    check("ar_rsp", 32'(a_rsp_valid), 32'h1);
    check("ar_data", 32'(a_rsp_data), 32'h1111);
    a_addr = 16'h0002;
    #1;
    rst = 1'b1;
    #1;
    check("ar_squash", 32'(a_rsp_valid), 32'h0);
    check("ar_gate", 32'(a_ready), 32'h0);
    tick();
    check("ar_norsp", 32'(a_rsp_valid), 32'h0);
    rst = 1'b0;
    a_valid = 2'b11; a_addr = 16'h0201;
    #1;
    check("ar_first", 32'(a_ready), 32'h1);
    tick();
    a_valid = 2'b00;
    #1;
    check("ar_first_rsp", 32'(a_rsp_valid), 32'h1);
    tick();

    // NREQ=4: requesters 1 and 3 continuous after reset -> 1,3,1,3.
    b_valid = 4'b1010; b_addr = 32'h4433_2211;
    prev_b = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      exp_b = (k % 2 == 0) ? 4'b0010 : 4'b1000;
      #1;
      check("b_wrap_ready", 32'(b_ready), 32'(exp_b));
      check("b_wrap_rsp", 32'(b_rsp_valid), 32'(prev_b));
      prev_b = exp_b;
      tick();
    end
    check("b_wrap_data", 32'(b_rsp_data), 32'hA5A5);

    // NREQ=4: all valid after last grant 3 -> 0,1,2,3.
    b_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      exp_b = 4'(1 << k);
      #1;
      check("b_fair_ready", 32'(b_ready), 32'(exp_b));
      check("b_fair_rsp", 32'(b_rsp_valid), 32'(prev_b));
      prev_b = exp_b;
      tick();
    end
    b_valid = 4'b0000;
    #1;
    check("b_last_rsp", 32'(b_rsp_valid), 32'h8);
    check("b_idle_ready", 32'(b_ready), 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
